spi_master_arbiter: RTL and testbench

- Shares one SPI master between NREQ independent requesters.
- Each requester submits a packet plus its packet size over a val/rdy interface.
- The arbiter picks one requester by round-robin, then configures the master: chip-select address equals the requester index, and packet size is taken from the requester.
- It issues the packet, captures the master's response and routes it back to the owning requester. Only one transaction is outstanding at a time.

---
 rtl/spi_arb_pkg.sv | 19 +
 rtl/spi_master_arbiter_if.sv | 47 ++++
 rtl/spi_rr_arbiter.sv | 41 ++++
 rtl/spi_master_arbiter.sv | 104 ++++++++++
 tb/tb_spi_master_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI master arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    // A size of zero or beyond the packet width means "send the full packet".
    function automatic int unsigned clamp_pkt_size(input int unsigned size,
                                                   input int unsigned nbits);
        if (size == 0 || size > nbits) return nbits;
        return size;
    endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Requester-side and SPI-master-side val/rdy bundle for the arbiter.
interface spi_master_arbiter_if #(
    parameter int unsigned NBITS = 32,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned ADDR_BITS = $clog2(NREQ);
    localparam int unsigned PSW       = $clog2(NBITS) + 1;

    logic [NREQ*NBITS-1:0] req_recv_msg;
    logic [NREQ*PSW-1:0]   req_pkt_size;
    logic [NREQ-1:0]       req_recv_val;
    logic [NREQ-1:0]       req_recv_rdy;

    logic [NBITS-1:0]      resp_send_msg;
    logic [NREQ-1:0]       resp_send_val;
    logic [NREQ-1:0]       resp_send_rdy;

    logic [ADDR_BITS-1:0]  spi_cs_addr_msg;
    logic                  spi_cs_addr_val;
    logic [PSW-1:0]        spi_pkt_size_msg;
    logic                  spi_pkt_size_val;
    logic [NBITS-1:0]      spi_send_msg;
    logic                  spi_send_val;
    logic                  spi_send_rdy;
    logic [NBITS-1:0]      spi_recv_msg;
    logic                  spi_recv_val;
    logic                  spi_recv_rdy;

    // Arbiter side.
    modport master (
        input  req_recv_msg, req_pkt_size, req_recv_val, resp_send_rdy,
               spi_send_rdy, spi_recv_msg, spi_recv_val,
        output req_recv_rdy, resp_send_msg, resp_send_val,
               spi_cs_addr_msg, spi_cs_addr_val, spi_pkt_size_msg, spi_pkt_size_val,
               spi_send_msg, spi_send_val, spi_recv_rdy
    );

    // Requesters plus SPI master side.
    modport slave (
        output req_recv_msg, req_pkt_size, req_recv_val, resp_send_rdy,
               spi_send_rdy, spi_recv_msg, spi_recv_val,
        input  req_recv_rdy, resp_send_msg, resp_send_val,
               spi_cs_addr_msg, spi_cs_addr_val, spi_pkt_size_msg, spi_pkt_size_val,
               spi_send_msg, spi_send_val, spi_recv_rdy
    );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Round-robin grant selection with its own priority pointer register.
module spi_rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned AW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            upd_en,
    input  logic [AW-1:0]   upd_val,
    output logic [NREQ-1:0] grant_oh,
    output logic [AW-1:0]   grant_idx,
    output logic            any_req
);

    logic [AW-1:0] ptr;

    always_ff @(posedge clk) begin
        if (reset)       ptr <= '0;
        else if (upd_en) ptr <= upd_val;
    end

    // First set request at or above ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        logic [AW:0] idx;
        grant_oh  = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + (AW+1)'(i);
            if (idx >= (AW+1)'(NREQ)) idx = idx - (AW+1)'(NREQ);
            if (!any_req && req[idx[AW-1:0]]) begin
                any_req   = 1'b1;
                grant_idx = idx[AW-1:0];
            end
        end
        if (any_req) grant_oh[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master among NREQ requesters: round-robin grant, configure,
// issue the packet, collect the response and return it to the owner.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NBITS = 32,
    parameter int unsigned NREQ  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_master_arbiter_if.master bus
);

    localparam int unsigned ADDR_BITS = $clog2(NREQ);
    localparam int unsigned PSW       = $clog2(NBITS) + 1;

    state_t               state, state_next;
    logic [ADDR_BITS-1:0] grant_q, grant_idx, ptr_next;
    logic [NREQ-1:0]      grant_oh;
    logic                 any_req;
    logic [NBITS-1:0]     pkt_q, resp_q, pkt_sel;
    logic [PSW-1:0]       size_q, size_sel;
    logic                 accept, send_fire, recv_fire, resp_fire;

    assign accept    = (state == IDLE)  && any_req;
    assign send_fire = (state == ISSUE) && bus.spi_send_rdy;
    assign recv_fire = (state == WAIT)  && bus.spi_recv_val;
    assign resp_fire = (state == RESP)  && bus.resp_send_rdy[grant_q];

    assign ptr_next = (grant_q == ADDR_BITS'(NREQ - 1)) ? '0 : grant_q + 1'b1;
    assign pkt_sel  = bus.req_recv_msg[grant_idx*NBITS +: NBITS];
    assign size_sel = bus.req_pkt_size[grant_idx*PSW +: PSW];

    spi_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.req_recv_val),
        .upd_en    (resp_fire),
        .upd_val   (ptr_next),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = CONFIG;
            CONFIG:                 state_next = ISSUE;
            ISSUE:   if (send_fire) state_next = WAIT;
            WAIT:    if (recv_fire) state_next = RESP;
            RESP:    if (resp_fire) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_recv_rdy     = '0;
        bus.resp_send_val    = '0;
        bus.spi_cs_addr_val  = 1'b0;
        bus.spi_pkt_size_val = 1'b0;
        bus.spi_send_val     = 1'b0;
        bus.spi_recv_rdy     = 1'b0;
        case (state)
            IDLE:    bus.req_recv_rdy = grant_oh;
            CONFIG: begin
                bus.spi_cs_addr_val  = 1'b1;
                bus.spi_pkt_size_val = 1'b1;
            end
            ISSUE:   bus.spi_send_val  = 1'b1;
            WAIT:    bus.spi_recv_rdy  = 1'b1;
            RESP:    bus.resp_send_val = NREQ'(1) << grant_q;
            default: ;
        endcase
    end

    // Transaction latches; size is stored already clamped to the packet width.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            pkt_q   <= '0;
            size_q  <= '0;
            resp_q  <= '0;
        end else begin
            if (accept) begin
                grant_q <= grant_idx;
                pkt_q   <= pkt_sel;
                size_q  <= PSW'(clamp_pkt_size(32'(size_sel), NBITS));
            end
            if (recv_fire) resp_q <= bus.spi_recv_msg;
        end
    end

    assign bus.spi_cs_addr_msg  = grant_q;
    assign bus.spi_pkt_size_msg = size_q;
    assign bus.spi_send_msg     = pkt_q;
    assign bus.resp_send_msg    = resp_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with immediate-assertion checks.
module tb_spi_master_arbiter;

    localparam int unsigned NBITS = 32;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned PSW   = 6;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_master_arbiter_if #(.NBITS(NBITS), .NREQ(NREQ)) bus ();

    spi_master_arbiter #(.NBITS(NBITS), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] msg, input logic [PSW-1:0] size);
        bus.req_recv_msg[i*NBITS +: NBITS] = msg;
        bus.req_pkt_size[i*PSW +: PSW]     = size;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_rdy"},  64'(bus.req_recv_rdy),     64'd0);
        chk({tag, "_resp_val"}, 64'(bus.resp_send_val),    64'd0);
        chk({tag, "_cs_val"},   64'(bus.spi_cs_addr_val),  64'd0);
        chk({tag, "_sz_val"},   64'(bus.spi_pkt_size_val), 64'd0);
        chk({tag, "_send_val"}, 64'(bus.spi_send_val),     64'd0);
        chk({tag, "_recv_rdy"}, 64'(bus.spi_recv_rdy),     64'd0);
    endtask

    // One full transaction starting in IDLE; vals stay asserted until the end.
    task automatic run_txn(input logic [3:0] vals, input int g, input logic [31:0] pkt,
                           input logic [PSW-1:0] size, input logic [31:0] rsp,
                           input int send_stall, input int resp_stall);
        logic [3:0] own;
        own = 4'(1 << g);
        bus.req_recv_val = vals;
        settle();
        chk("accept_rdy", 64'(bus.req_recv_rdy), 64'(own));
        tick();
        chk("cfg_cs_val",   64'(bus.spi_cs_addr_val),  64'd1);
        chk("cfg_sz_val",   64'(bus.spi_pkt_size_val), 64'd1);
        chk("cfg_cs_addr",  64'(bus.spi_cs_addr_msg),  64'(g));
        chk("cfg_size",     64'(bus.spi_pkt_size_msg), 64'(size));
        chk("cfg_send_val", 64'(bus.spi_send_val),     64'd0);
        chk("cfg_req_rdy",  64'(bus.req_recv_rdy),     64'd0);
        tick();
        for (int i = 0; i < send_stall; i++) begin
            chk("stall_send_val", 64'(bus.spi_send_val), 64'd1);
            chk("stall_send_msg", 64'(bus.spi_send_msg), 64'(pkt));
            tick();
        end
        bus.spi_send_rdy = 1'b1;
        settle();
        chk("issue_send_val", 64'(bus.spi_send_val), 64'd1);
        chk("issue_send_msg", 64'(bus.spi_send_msg), 64'(pkt));
        tick();
        bus.spi_send_rdy = 1'b0;
        chk("wait_recv_rdy", 64'(bus.spi_recv_rdy), 64'd1);
        chk("wait_send_val", 64'(bus.spi_send_val), 64'd0);
        bus.spi_recv_val = 1'b1;
        bus.spi_recv_msg = rsp;
        tick();
        bus.spi_recv_val = 1'b0;
        for (int i = 0; i < resp_stall; i++) begin
            bus.resp_send_rdy = ~own;
            settle();
            chk("hold_resp_val", 64'(bus.resp_send_val), 64'(own));
            chk("hold_resp_msg", 64'(bus.resp_send_msg), 64'(rsp));
            chk("hold_req_rdy",  64'(bus.req_recv_rdy),  64'd0);
            tick();
        end
        bus.resp_send_rdy = own;
        settle();
        chk("resp_val",     64'(bus.resp_send_val), 64'(own));
        chk("resp_msg",     64'(bus.resp_send_msg), 64'(rsp));
        chk("resp_recv_rdy", 64'(bus.spi_recv_rdy), 64'd0);
        tick();
        bus.resp_send_rdy = '0;
        bus.req_recv_val  = '0;
        settle();
        chk("idle_resp_val", 64'(bus.resp_send_val), 64'd0);
        chk("idle_resp_msg", 64'(bus.resp_send_msg), 64'(rsp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        bus.req_recv_msg  = '0;
        bus.req_pkt_size  = '0;
        bus.req_recv_val  = '0;
        bus.resp_send_rdy = '0;
        bus.spi_send_rdy  = 1'b0;
        bus.spi_recv_msg  = '0;
        bus.spi_recv_val  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk_quiet("rst");
        chk("rst_cs_msg",   64'(bus.spi_cs_addr_msg),  64'd0);
        chk("rst_sz_msg",   64'(bus.spi_pkt_size_msg), 64'd0);
        chk("rst_send_msg", 64'(bus.spi_send_msg),     64'd0);
        chk("rst_resp_msg", 64'(bus.resp_send_msg),    64'd0);

        // Single request from requester 2.
        set_req(2, 32'hA5A5_0001, 6'd16);
        run_txn(4'b0100, 2, 32'hA5A5_0001, 6'd16, 32'h0000_1234, 0, 0);

        // Contention after a fresh reset, with size clamping and backpressure.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 32'hC0DE_0000, 6'd0);
        set_req(1, 32'hC0DE_0001, 6'd40);
        set_req(2, 32'hC0DE_0002, 6'd32);
        set_req(3, 32'hC0DE_0003, 6'd1);
        run_txn(4'b1111, 0, 32'hC0DE_0000, 6'd32, 32'h5000_0000, 0, 0);
        run_txn(4'b1111, 1, 32'hC0DE_0001, 6'd32, 32'h5000_0001, 5, 0);
        run_txn(4'b1111, 2, 32'hC0DE_0002, 6'd32, 32'h5000_0002, 0, 3);
        run_txn(4'b1111, 3, 32'hC0DE_0003, 6'd1,  32'h5000_0003, 0, 0);
        run_txn(4'b1111, 0, 32'hC0DE_0000, 6'd32, 32'h5000_0004, 0, 0);

        // Pointer wrap: lone 3, then 0 and 3 together.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_txn(4'b1000, 3, 32'hC0DE_0003, 6'd1,  32'h6000_0003, 0, 0);
        run_txn(4'b1001, 0, 32'hC0DE_0000, 6'd32, 32'h6000_0000, 0, 0);

        // Reset while waiting on the master's response for requester 1.
        bus.req_recv_val = 4'b0010;
        settle();
        chk("rw_accept_rdy", 64'(bus.req_recv_rdy), 64'h2);
        tick();
        bus.req_recv_val = '0;
        tick();
        bus.spi_send_rdy = 1'b1;
        tick();
        bus.spi_send_rdy = 1'b0;
        chk("rw_in_wait", 64'(bus.spi_recv_rdy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk_quiet("rw");
        chk("rw_resp_msg", 64'(bus.resp_send_msg), 64'd0);
        chk("rw_send_msg", 64'(bus.spi_send_msg),  64'd0);

        // Late master response lands in IDLE and must be dropped.
        bus.spi_recv_val = 1'b1;
        bus.spi_recv_msg = 32'hDEAD_BEEF;
        tick();
        bus.spi_recv_val = 1'b0;
        settle();
        chk("late_resp_val", 64'(bus.resp_send_val), 64'd0);
        chk("late_resp_msg", 64'(bus.resp_send_msg), 64'd0);
        chk("late_cs_val",   64'(bus.spi_cs_addr_val), 64'd0);

        // Pointer restarted at 0, then requester 3 gets a fresh transaction.
        run_txn(4'b1001, 0, 32'hC0DE_0000, 6'd32, 32'h7000_0000, 0, 0);
        run_txn(4'b1000, 3, 32'hC0DE_0003, 6'd1,  32'h7000_0003, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
